dma_fifo_buffer: RTL and testbench
==================================

Name: dma_fifo_buffer

Overview:
Parametrised successor to the single-word DMA staging register: a synchronous circular FIFO between the bus-side DMA engine (producer) and the peripheral/protocol side (consumer).
- Adds configurable width and depth, occupancy reporting, an almost-full threshold, a synchronous flush and sticky overflow/underflow error flags.
- Sits in the DMA datapath. Write strobe comes from the DMA transfer FSM; read strobe comes from the protocol serialiser.

Parameters:
DATA_W, 32, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, 6, level at or above which almost_full asserts (1..DEPTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  push wr_data this cycle
wr_data  in  DATA_W  write word
rd_en  in  1  pop head word this cycle
rd_data  out  DATA_W  registered read word, valid the cycle after an accepted pop
rd_valid  out  1  high for one cycle when rd_data carries a newly popped word
flush  in  1  synchronous clear of contents
clr_err  in  1  clears overflow/underflow
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_LEVEL
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: push attempted while full and not accepted
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Hence full=0, empty=1, almost_full=0. Storage array is not reset.
- full, empty and almost_full are combinational decodes of the registered level. No state machine beyond the pointer/level registers.
- Push accepted iff wr_en && (!full || rd_en). Accepted push writes mem[wr_ptr] and increments wr_ptr modulo DEPTH (natural wrap, log2(DEPTH) bits).
- Pop accepted iff rd_en && !empty. Accepted pop loads rd_data<=mem[rd_ptr], sets rd_valid=1 next cycle and increments rd_ptr modulo DEPTH. Otherwise rd_valid=0 and rd_data holds its last value.
- Read latency is 1 cycle. There is no fall-through: a word pushed in cycle N is poppable at the earliest in cycle N+1.
- Simultaneous accepted push and pop leaves level unchanged.
  - When full, the push is accepted because the pop frees a slot in the same edge.
  - When empty, only the push is accepted; the pop is an underflow.
- Level update: +1 on push only, -1 on pop only, else hold. It never exceeds DEPTH and never underflows 0.
- Overflow sets on wr_en && full && !rd_en. The word is dropped and no state changes except the flag.
- Underflow sets on rd_en && empty. rd_valid stays 0.
- Flags hold until clr_err or reset. If clr_err and a new error occur in the same cycle, the set wins.
- flush has highest priority over wr_en/rd_en in its cycle:
  - Pointers and level go to 0 and rd_valid goes to 0.
  - rd_data and the error flags are unaffected.
  - Pushes or pops in the flush cycle are ignored and raise no errors.
- Reset asserted mid-transfer discards all contents immediately. The first accepted push after release lands in mem[0].

Decomposition:
- Shared package dma_pkg:
  - DMA_DATA_W=32 default.
  - clog2-based width helper/constant for level and pointer widths.
  - Error-flag bit indices (ERR_OVF=0, ERR_UDF=1) for status-register packing by the DMA control block.
- One natural sub-module: dma_buffer_ram.
  - DEPTH x DATA_W simple dual-port array: synchronous write, synchronous registered read, no reset.
  - The top holds pointers, level, flags and control.

Test Plan:
- Reset then idle -> empty=1, full=0, level=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
- DEPTH=8: push 0x11..0x88 on 8 consecutive cycles -> level=8, full=1, almost_full=1 from level 6.
  - 9th push of 0x99 -> overflow=1, level stays 8.
  - 8 pops -> rd_data 0x11..0x88 in order, each one cycle after its rd_en, rd_valid per word.
- Wrap-around: push 6, pop 6, push 8 (0xA0..0xA7), pop 8 -> correct order across the pointer wrap, empty=1 at end.
- While full, assert wr_en and rd_en together with wr_data=0xCAFE -> level stays 8, no overflow, head popped. 0xCAFE emerges last after draining.
- Pop when empty -> underflow=1, rd_valid=0. Then clr_err and a new rd_en in the same cycle -> underflow remains 1. clr_err alone -> 0.
- Push 5 then flush with wr_en=1 -> level=0, empty=1, no overflow. Separately, pull rst_n low mid-burst off a clock edge -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA constants, error-bit indices and width helpers
package dma_pkg;
    localparam int DMA_DATA_W = 32;
    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/dma_fifo_buffer_if.sv
// dma_fifo_buffer_if: producer/consumer handshake and status bundle of the DMA FIFO
interface dma_fifo_buffer_if
    import dma_pkg::*;
#(
    parameter int DATA_W = DMA_DATA_W,
    parameter int DEPTH  = 8
);
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic                      rd_en;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_valid;
    logic                      flush;
    logic                      clr_err;
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic [lvl_w(DEPTH)-1:0]   level;
    logic                      overflow;
    logic                      underflow;
    modport master (
        output wr_en, wr_data, rd_en, flush, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, level, overflow, underflow
    );
    modport slave (
        input  wr_en, wr_data, rd_en, flush, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, level, overflow, underflow
    );
endinterface

// File: rtl/dma_buffer_ram.sv
// dma_buffer_ram: DEPTH x DATA_W dual-port array, sync write, registered read, no reset
module dma_buffer_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       re_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_W-1:0]          rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/dma_fifo_buffer.sv
// dma_fifo_buffer: circular FIFO with occupancy, almost-full, flush and sticky error flags
module dma_fifo_buffer
    import dma_pkg::*;
#(
    parameter int DATA_W   = DMA_DATA_W,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input logic               clk,
    input logic               rst_n,
    dma_fifo_buffer_if.slave  bus
);
    localparam int AW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [1:0]        err_q, err_d, err_set;
    logic              rd_valid_q, seen_q, seen_d;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] ram_rdata;
    always_comb begin
        full            = level_q == LW'(DEPTH);
        empty           = level_q == '0;
        push            = bus.wr_en && (!full || bus.rd_en) && !bus.flush;
        pop             = bus.rd_en && !empty && !bus.flush;
        err_set         = '0;
        err_set[ERR_OVF] = bus.wr_en && full && !bus.rd_en && !bus.flush;
        err_set[ERR_UDF] = bus.rd_en && empty && !bus.flush;
        err_d           = (bus.clr_err ? 2'b00 : err_q) | err_set;
        wr_ptr_d        = bus.flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d        = bus.flush ? '0 : rd_ptr_q + AW'(pop);
        level_d         = bus.flush ? '0 : level_q + LW'(push) - LW'(pop);
        seen_d          = seen_q | pop;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            err_q      <= '0;
            rd_valid_q <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            err_q      <= err_d;
            rd_valid_q <= pop;
            seen_q     <= seen_d;
        end
    end
    dma_buffer_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );
    // The RAM read register is unreset, so rd_data reads 0 until the first pop since reset
    assign bus.rd_data     = seen_q ? ram_rdata : '0;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = level_q >= LW'(AF_LEVEL);
    assign bus.level       = level_q;
    assign bus.overflow    = err_q[ERR_OVF];
    assign bus.underflow   = err_q[ERR_UDF];
endmodule

// File: tb/tb_dma_fifo_buffer.sv
// tb_dma_fifo_buffer: directed and random stimulus against a queue-based reference model
module tb_dma_fifo_buffer;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] q[$];
    logic        m_ovf, m_udf, m_valid;
    logic [31:0] m_data;
    dma_fifo_buffer_if #(.DATA_W(32), .DEPTH(DEPTH)) bus ();
    dma_fifo_buffer #(.DATA_W(32), .DEPTH(DEPTH), .AF_LEVEL(AF)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic compare_all(input string ctx);
        check({ctx, ".level"}, 64'(bus.level), 64'(q.size()));
        check({ctx, ".full"}, 64'(bus.full), 64'(q.size() == DEPTH));
        check({ctx, ".empty"}, 64'(bus.empty), 64'(q.size() == 0));
        check({ctx, ".almost_full"}, 64'(bus.almost_full), 64'(q.size() >= AF));
        check({ctx, ".overflow"}, 64'(bus.overflow), 64'(m_ovf));
        check({ctx, ".underflow"}, 64'(bus.underflow), 64'(m_udf));
        check({ctx, ".rd_valid"}, 64'(bus.rd_valid), 64'(m_valid));
        check({ctx, ".rd_data"}, 64'(bus.rd_data), 64'(m_data));
    endtask
    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_valid = 0;
        m_data = '0;
    endtask
    task automatic cycle(input string ctx, input logic w, input logic [31:0] wd, input logic r,
                         input logic f, input logic c);
        logic push_ok;
        bus.wr_en = w;
        bus.wr_data = wd;
        bus.rd_en = r;
        bus.flush = f;
        bus.clr_err = c;
        if (c) begin
            m_ovf = 0;
            m_udf = 0;
        end
        m_valid = 0;
        if (f) q.delete();
        else begin
            if (w && q.size() == DEPTH && !r) m_ovf = 1;
            if (r && q.size() == 0) m_udf = 1;
            push_ok = w && (q.size() < DEPTH || r);
            if (r && q.size() > 0) begin
                m_data = q.pop_front();
                m_valid = 1;
            end
            if (push_ok) q.push_back(wd);
        end
        @(posedge clk);
        @(negedge clk);
        compare_all(ctx);
    endtask
    initial begin
        int bias_w, bias_r;
        rst_n = 1'b0;
        bus.wr_en = 0;
        bus.wr_data = '0;
        bus.rd_en = 0;
        bus.flush = 0;
        bus.clr_err = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;
        cycle("idle", 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) cycle("fill", 1, 32'h11 * i, 0, 0, 0);
        cycle("ovf", 1, 32'h99, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle("drain", 0, 0, 1, 0, 0);
        cycle("clr", 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle("wpush", 1, 32'h50 + i, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle("wpop", 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cycle("wpush8", 1, 32'hA0 + i, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle("wpop8", 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cycle("refill", 1, 32'hB0 + i, 0, 0, 0);
        cycle("fullrw", 1, 32'hCAFE, 1, 0, 0);
        for (int i = 0; i < 9; i++) cycle("drain2", 0, 0, 1, 0, 0);
        cycle("udf_clr", 0, 0, 1, 0, 1);
        cycle("clr_only", 0, 0, 0, 0, 1);
        cycle("empty_rw", 1, 32'h1234, 1, 0, 0);
        cycle("pop1", 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle("pre_flush", 1, 32'hD0 + i, 0, 0, 0);
        cycle("flush", 1, 32'hDEAD, 1, 1, 0);
        cycle("post_flush", 1, 32'hE0, 0, 0, 0);
        cycle("post_flush_pop", 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle("burst", 1, 32'hF0 + i, i[0], 0, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all("async_rst");
        @(negedge clk);
        compare_all("rst_hold");
        rst_n = 1'b1;
        cycle("after_rst_push", 1, 32'h777, 0, 0, 0);
        cycle("after_rst_pop", 0, 0, 1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                bias_w = $urandom_range(20, 80);
                bias_r = $urandom_range(20, 80);
            end
            cycle("rand", $urandom_range(0, 99) < bias_w, $urandom, $urandom_range(0, 99) < bias_r,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
